// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and stall controller for the 16-bit five-stage core. It compares the
//   decode-stage source registers against the instruction held in ID/EX. From
//   that it steers hold, bubble and flush controls into PC, IF/ID, ID/EX and
//   EX/MEM. It covers load-use stalls, EX-resolved redirects, data-memory waits
//   (guarded by a watchdog) and the drain that follows a halt.
//
// Ports
//   clk, rst                        clock (rising edge), async active-high reset
//   id_valid                        decode holds a real instruction
//   id_rs_num, id_rt_num            decode source register numbers
//   id_rs_used, id_rt_used          source register actually read
//   idex_memReadEnable              instruction in EX is a load
//   idex_regWriteEnable             instruction in EX writes a register
//   idex_regWriteNum                destination register of the EX instruction
//   idex_halt                       halt sitting in ID/EX
//   ex_redirect                     taken branch/jump resolved in EX
//   mem_busy                        data memory not done this cycle
//   pc_hold, ifid_hold, idex_hold,  recirculate the corresponding register
//   exmem_hold
//   ifid_flush                      load a NOP into IF/ID
//   idex_bubble                     load a NOP into ID/EX
//   halted                          pipeline drained after halt
//   err_timeout                     sticky memory watchdog error
//   stall_cnt, flush_cnt            saturating event counters
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int DRAIN       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs_num,
  input  logic [2:0]       id_rt_num,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             idex_memReadEnable,
  input  logic             idex_regWriteEnable,
  input  logic [2:0]       idex_regWriteNum,
  input  logic             idex_halt,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int DRN_W  = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEMWAIT,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t              state, state_nx;
  logic [WAIT_W-1:0]   wait_cnt, wait_nx;
  logic [DRN_W-1:0]    drain_cnt, drain_nx;

  logic load_use;
  logic run_rules;
  logic stall_inc, flush_inc, timeout_set;
  logic pc_hold_c, ifid_hold_c, idex_hold_c, exmem_hold_c;
  logic ifid_flush_c, idex_bubble_c;

  assign load_use = id_valid & idex_memReadEnable & idex_regWriteEnable &
                    ((id_rs_used & (id_rs_num == idex_regWriteNum)) |
                     (id_rt_used & (id_rt_num == idex_regWriteNum)));

  // The release cycle of a memory wait is handled exactly like a RUN cycle,
  // so a redirect or load-use held back during the wait acts immediately.
  assign run_rules = (state == ST_RUN) || ((state == ST_MEMWAIT) && !mem_busy);

  always_comb begin
    state_nx      = state;
    wait_nx       = wait_cnt;
    drain_nx      = drain_cnt;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    timeout_set   = 1'b0;
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    idex_hold_c   = 1'b0;
    exmem_hold_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;

    case (state)
      ST_MEMWAIT: begin
        if (mem_busy) begin
          pc_hold_c    = 1'b1;
          ifid_hold_c  = 1'b1;
          idex_hold_c  = 1'b1;
          exmem_hold_c = 1'b1;
          stall_inc    = 1'b1;
          if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
            timeout_set = 1'b1;
            state_nx    = ST_HALTED;
          end else begin
            wait_nx = wait_cnt + WAIT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        pc_hold_c     = 1'b1;
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        if (mem_busy) begin
          exmem_hold_c = 1'b1;
        end else if (drain_cnt <= DRN_W'(1)) begin
          drain_nx = '0;
          state_nx = ST_HALTED;
        end else begin
          drain_nx = drain_cnt - DRN_W'(1);
        end
      end
      ST_HALTED: begin
        pc_hold_c     = 1'b1;
        ifid_hold_c   = 1'b1;
        idex_bubble_c = 1'b1;
      end
      default: ;
    endcase

    if (run_rules) begin
      state_nx = ST_RUN;
      wait_nx  = '0;
      if (mem_busy) begin
        pc_hold_c    = 1'b1;
        ifid_hold_c  = 1'b1;
        idex_hold_c  = 1'b1;
        exmem_hold_c = 1'b1;
        stall_inc    = 1'b1;
        if (MEM_TIMEOUT <= 1) begin
          timeout_set = 1'b1;
          state_nx    = ST_HALTED;
        end else begin
          state_nx = ST_MEMWAIT;
          wait_nx  = WAIT_W'(1);
        end
      end else if (idex_halt) begin
        pc_hold_c     = 1'b1;
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        state_nx      = ST_DRAIN;
        drain_nx      = DRN_W'(DRAIN);
      end else if (ex_redirect) begin
        // A redirect squashes any load-use dependent, so it wins outright.
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        flush_inc     = 1'b1;
      end else if (load_use) begin
        pc_hold_c     = 1'b1;
        ifid_hold_c   = 1'b1;
        idex_bubble_c = 1'b1;
        stall_inc     = 1'b1;
      end
    end
  end

  // Controls are forced low for as long as reset is applied.
  assign pc_hold     = pc_hold_c     & ~rst;
  assign ifid_hold   = ifid_hold_c   & ~rst;
  assign idex_hold   = idex_hold_c   & ~rst;
  assign exmem_hold  = exmem_hold_c  & ~rst;
  assign ifid_flush  = ifid_flush_c  & ~rst;
  assign idex_bubble = idex_bubble_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      drain_cnt <= drain_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted      <= 1'b0;
      err_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      halted      <= (state_nx == ST_HALTED);
      err_timeout <= err_timeout | timeout_set;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CNT_W=4, MEM_TIMEOUT=15, DRAIN=2).
// ctl packs {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_bubble}.
module tb_hazard_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [2:0]    id_rs_num, id_rt_num;
  logic          id_rs_used, id_rt_used;
  logic          ld, wen;
  logic [2:0]    wnum;
  logic          halt, redir, busy;
  logic          pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_bubble;
  logic          halted, err_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [5:0]    ctl;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(15), .DRAIN(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_valid            (id_valid),
    .id_rs_num           (id_rs_num),
    .id_rt_num           (id_rt_num),
    .id_rs_used          (id_rs_used),
    .id_rt_used          (id_rt_used),
    .idex_memReadEnable  (ld),
    .idex_regWriteEnable (wen),
    .idex_regWriteNum    (wnum),
    .idex_halt           (halt),
    .ex_redirect         (redir),
    .mem_busy            (busy),
    .pc_hold             (pc_hold),
    .ifid_hold           (ifid_hold),
    .idex_hold           (idex_hold),
    .exmem_hold          (exmem_hold),
    .ifid_flush          (ifid_flush),
    .idex_bubble         (idex_bubble),
    .halted              (halted),
    .err_timeout         (err_timeout),
    .stall_cnt           (stall_cnt),
    .flush_cnt           (flush_cnt)
  );

  assign ctl = {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_valid = 1'b0; id_rs_num = 3'd0; id_rt_num = 3'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0;
    ld = 1'b0; wen = 1'b0; wnum = 3'd0;
    halt = 1'b0; redir = 1'b0; busy = 1'b0;
  endtask

  // load r3 in EX, decode reads rs=r3
  task automatic set_lu();
    id_valid = 1'b1; id_rs_num = 3'd3; id_rs_used = 1'b1;
    ld = 1'b1; wen = 1'b1; wnum = 3'd3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    clr();
    rst = 1'b0;
    #3;

    // Reset with an active load-use pattern on the inputs: everything low.
    set_lu();
    rst = 1'b1;
    #1;
    chk("rst_ctl", ctl, 6'b000000);
    chk("rst_halted", halted, 0);
    chk("rst_err", err_timeout, 0);
    tick();
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    rst = 1'b0;
    clr();
    #1;

    // Load-use on rs.
    set_lu();
    #1;
    chk("lu_ctl", ctl, 6'b110001);
    tick();
    ld = 1'b0;
    #1;
    chk("lu_release_ctl", ctl, 6'b000000);
    chk("lu_stall", stall_cnt, 1);
    // Same registers but rs not used: no stall.
    set_lu(); id_rs_used = 1'b0;
    #1;
    chk("lu_unused_ctl", ctl, 6'b000000);
    tick();
    chk("lu_unused_stall", stall_cnt, 1);
    // rt match, but EX instruction does not write.
    set_lu(); id_rs_used = 1'b0; id_rt_used = 1'b1; id_rt_num = 3'd3; wen = 1'b0;
    #1;
    chk("lu_nowen_ctl", ctl, 6'b000000);
    // rt match with write: stall.
    wen = 1'b1;
    #1;
    chk("lu_rt_ctl", ctl, 6'b110001);
    // Invalid decode slot: no stall.
    id_valid = 1'b0;
    #1;
    chk("lu_invalid_ctl", ctl, 6'b000000);
    // Different register number: no stall.
    set_lu(); wnum = 3'd4;
    #1;
    chk("lu_other_reg_ctl", ctl, 6'b000000);
    tick();
    chk("lu_other_reg_stall", stall_cnt, 1);

    // Redirect coinciding with load-use: one flush, no stall.
    do_reset();
    set_lu(); redir = 1'b1;
    #1;
    chk("rdlu_ctl", ctl, 6'b000011);
    tick();
    clr();
    #1;
    chk("rdlu_flush", flush_cnt, 1);
    chk("rdlu_stall", stall_cnt, 0);

    // mem_busy for 3 cycles with redirect asserted throughout.
    do_reset();
    busy = 1'b1; redir = 1'b1;
    #1;
    chk("mw_c1_ctl", ctl, 6'b111100);
    tick();
    chk("mw_c2_ctl", ctl, 6'b111100);
    chk("mw_c2_stall", stall_cnt, 1);
    tick();
    chk("mw_c3_ctl", ctl, 6'b111100);
    tick();
    busy = 1'b0;
    #1;
    chk("mw_release_ctl", ctl, 6'b000011);
    chk("mw_release_stall", stall_cnt, 3);
    chk("mw_release_flush", flush_cnt, 0);
    tick();
    redir = 1'b0;
    #1;
    chk("mw_after_ctl", ctl, 6'b000000);
    chk("mw_after_stall", stall_cnt, 3);
    chk("mw_after_flush", flush_cnt, 1);

    // Reset in the middle of a memory wait leaves no residual hold.
    do_reset();
    busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mw_rst_ctl", ctl, 6'b000000);
    chk("mw_rst_stall", stall_cnt, 0);
    tick();
    rst = 1'b0;
    busy = 1'b0;
    #1;
    chk("mw_rst_after_ctl", ctl, 6'b000000);

    // Watchdog: 15 consecutive busy cycles.
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("wd_14_err", err_timeout, 0);
    chk("wd_14_halted", halted, 0);
    chk("wd_14_ctl", ctl, 6'b111100);
    tick();
    chk("wd_15_err", err_timeout, 1);
    chk("wd_15_halted", halted, 1);
    chk("wd_stall_sat", stall_cnt, 15);
    chk("wd_halted_ctl", ctl, 6'b110001);
    busy = 1'b0;
    tick();
    chk("wd_sticky_err", err_timeout, 1);
    chk("wd_sticky_ctl", ctl, 6'b110001);
    rst = 1'b1;
    #1;
    chk("wd_rst_ctl", ctl, 6'b000000);
    chk("wd_rst_err", err_timeout, 0);
    chk("wd_rst_halted", halted, 0);
    chk("wd_rst_stall", stall_cnt, 0);
    tick();
    rst = 1'b0;
    #1;

    // Halt drain, with a simultaneous redirect that halt outranks.
    do_reset();
    halt = 1'b1; redir = 1'b1;
    #1;
    chk("halt_run_ctl", ctl, 6'b100011);
    tick();
    clr();
    #1;
    chk("halt_d1_ctl", ctl, 6'b100011);
    chk("halt_d1_halted", halted, 0);
    chk("halt_flush_cnt", flush_cnt, 0);
    tick();
    chk("halt_d2_ctl", ctl, 6'b100011);
    chk("halt_d2_halted", halted, 0);
    tick();
    chk("halt_e3_halted", halted, 1);
    chk("halt_e3_ctl", ctl, 6'b110001);
    set_lu(); redir = 1'b1;
    tick();
    tick();
    chk("halt_stay_halted", halted, 1);
    chk("halt_stay_ctl", ctl, 6'b110001);
    chk("halt_stay_flush", flush_cnt, 0);

    // mem_busy during drain freezes the countdown and holds EX/MEM.
    do_reset();
    halt = 1'b1;
    tick();
    halt = 1'b0; busy = 1'b1;
    #1;
    chk("dbusy_ctl", ctl, 6'b100111);
    tick();
    tick();
    chk("dbusy_halted", halted, 0);
    chk("dbusy_stall", stall_cnt, 0);
    busy = 1'b0;
    tick();
    chk("dbusy_d1_halted", halted, 0);
    chk("dbusy_d1_ctl", ctl, 6'b100011);
    tick();
    chk("dbusy_done_halted", halted, 1);

    // Saturation: 20 consecutive load-use stalls with a 4-bit counter.
    do_reset();
    set_lu();
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", stall_cnt, 14);
    tick();
    chk("sat_15", stall_cnt, 15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_20", stall_cnt, 15);
    chk("sat_ctl", ctl, 6'b110001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 16-bit five-stage core, sitting alongside the ID/EX stage register and steering it. It compares decode-stage source registers against the instruction latched in ID/EX, and then drives hold, bubble and flush controls into PC, IF/ID, ID/EX and EX/MEM. It handles four conditions:

- load-use stalls
- EX-resolved branch/jump redirects
- multi-cycle data-memory waits, with a watchdog
- halt drain

It also keeps saturating stall/flush event counters.

## Interface
Parameters:
- CNT_W, 16, width of each event counter
- MEM_TIMEOUT, 15, number of consecutive mem_busy cycles that are tolerated before an error
- DRAIN, 2, cycles from halt detection until the pipeline is empty (MEM, then WB)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs_num, id_rt_num  in  3 each  decode source register numbers
- id_rs_used, id_rt_used  in  1 each  source register is actually read
- idex_memReadEnable  in  1  ID/EX output: instruction in EX is a load
- idex_regWriteEnable  in  1  ID/EX output
- idex_regWriteNum  in  3  ID/EX output
- idex_halt  in  1  ID/EX halt_out
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle
- mem_busy  in  1  data memory not done this cycle
- pc_hold, ifid_hold, idex_hold, exmem_hold  out  1 each  recirculate the register
- ifid_flush  out  1  load a NOP into IF/ID
- idex_bubble  out  1  load NOP into ID/EX: all enables 0, nop_in=1
- halted  out  1  pipeline drained after halt
- err_timeout  out  1  sticky memory watchdog error
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- FSM states: RUN, MEMWAIT, DRAIN, HALTED.
- load_use = id_valid & idex_memReadEnable & idex_regWriteEnable & ((id_rs_used & id_rs_num==idex_regWriteNum) | (id_rt_used & id_rt_num==idex_regWriteNum)).
- Forwarding covers every other RAW case, so no further stalls are generated.
- Priority in RUN, highest first:
  1. **mem_busy**: assert all four holds, no bubble and no flush. Go to MEMWAIT with wait_cnt=1.
  2. **idex_halt**: assert ifid_flush, idex_bubble and pc_hold. Go to DRAIN with drain_cnt=DRAIN.
  3. **ex_redirect**: assert ifid_flush and idex_bubble; the 2-cycle penalty squashes the two younger instructions. flush_cnt += 1.
  4. **load_use**: assert pc_hold, ifid_hold and idex_bubble; this is a 1-cycle stall. stall_cnt += 1.
  5. Otherwise all controls are 0.
- MEMWAIT:
  - All four holds stay asserted while mem_busy. ex_redirect and load_use are ignored, because EX is frozen and the conditions are re-evaluated on release.
  - wait_cnt increments each busy cycle.
  - mem_busy=0: holds drop in that same cycle and the state returns to RUN. The RUN priority rules apply in that cycle.
  - wait_cnt reaches MEM_TIMEOUT with mem_busy still 1: set err_timeout and go to HALTED.
- DRAIN:
  - pc_hold=1 and ifid_flush=1 every cycle, and idex_bubble=1.
  - drain_cnt decrements each cycle; at 0 go to HALTED.
  - mem_busy during DRAIN freezes drain_cnt and asserts exmem_hold.
- HALTED:
  - pc_hold, ifid_hold and idex_bubble are held at 1 and halted=1.
  - The only exit is rst.
- Counters:
  - stall_cnt counts load-use stall cycles plus MEMWAIT cycles.
  - flush_cnt counts redirects.
  - Both saturate at all-ones and never wrap.
- Overlap rule: a redirect coinciding with load_use is one flush, not a stall (the dependent instruction is squashed). It counts in flush_cnt only.

## Timing
- All hold, bubble and flush outputs are combinational from the current state and inputs. They take effect at the next clk edge in the target stage registers.
- State, counters, halted and err_timeout are registered and update on the rising edge.
- While rst=1 (asynchronous), all outputs are 0:
  - state=RUN
  - wait_cnt=drain_cnt=0
  - stall_cnt=flush_cnt=0
  - halted=0, err_timeout=0
- Reset mid-DRAIN or mid-MEMWAIT aborts immediately, with no residual hold.
- halted rises DRAIN+1 edges after the edge that latched halt into ID/EX, provided mem_busy is not asserted.
- Load-use latency: the dependent instruction enters EX exactly one cycle late, and the forwarding path then supplies the load data from MEM/WB.

## Test plan
- **Load-use:** load r3 in EX, decode reads rs=3 with id_rs_used=1. Expect 1 cycle of pc_hold=ifid_hold=idex_bubble=1, then all 0; stall_cnt=1. Repeat with id_rs_used=0: no stall.
- **Redirect plus load-use in the same cycle:** expect ifid_flush=idex_bubble=1, pc_hold=0, flush_cnt=1, stall_cnt=0.
- **mem_busy for 3 cycles, with ex_redirect asserted throughout:** all holds are 1 for 3 cycles and there is no flush. On the release cycle ifid_flush=1; stall_cnt=3, flush_cnt=1.
- **Watchdog:** mem_busy stuck at 1 for MEM_TIMEOUT cycles. err_timeout=1 and the state is HALTED. After rst pulse mid-way, all outputs are 0.
- **Halt:** idex_halt=1 with DRAIN=2. Bubble/flush for 2 cycles, then halted=1 on the 3rd edge and pc_hold stays at 1 until rst.
- **Saturation:** CNT_W=4 with 20 load-use stalls. stall_cnt holds at 15.
